// File: rtl/cmd_credit_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_credit_arbiter_pkg
//  Description : Shared types and constants for the command credit arbiter.
//                Channel indices map the CU/AFU command buffers onto req_in.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmd_credit_arbiter_pkg;

    localparam int CMD_ARB_NUM_CHANNELS = 6;
    localparam int CREDIT_COUNT_W       = 7;

    // Arbitration mode as driven on priority_mode_in
    typedef enum logic {
        FIXED       = 1'b0,
        ROUND_ROBIN = 1'b1
    } arb_mode_e;

    typedef logic [CREDIT_COUNT_W-1:0] credit_count_t;

    // Channel numbers on req_in; index 0 is highest priority in fixed mode
    localparam int PRIORITY_RESTART        = 0;
    localparam int PRIORITY_WED            = 1;
    localparam int PRIORITY_WRITE          = 2;
    localparam int PRIORITY_READ           = 3;
    localparam int PRIORITY_PREFETCH_WRITE = 4;
    localparam int PRIORITY_PREFETCH_READ  = 5;

    // Credit pool indices
    localparam int POOL_READ  = 0;
    localparam int POOL_WRITE = 1;

endpackage
`default_nettype wire

// File: rtl/cmd_credit_arbiter_rr_priority_select.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_credit_arbiter_rr_priority_select
//  Description : Combinational search for the first set request bit at or
//                after a pointer, wrapping past the top index. A pointer of
//                zero gives plain lowest-index-first priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_credit_arbiter_rr_priority_select #(
    parameter int NUM_REQ = 6,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_index
);

    localparam logic [IDX_W:0] c_num_req = (IDX_W + 1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [2*NUM_REQ-1:0] w_req_shift;
    logic [NUM_REQ-1:0]   w_req_rot;
    logic [IDX_W-1:0]     w_offset;
    logic [IDX_W:0]       w_sum;

    // Rotate so bit k of w_req_rot is request (ptr + k) mod NUM_REQ
    assign w_req_dbl   = {i_req, i_req};
    assign w_req_shift = w_req_dbl >> i_ptr;
    assign w_req_rot   = w_req_shift[NUM_REQ-1:0];

    // Lowest set bit of the rotated vector, mapped back to a channel index
    always_comb begin
        o_found  = 1'b0;
        w_offset = '0;
        o_grant  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                o_found  = 1'b1;
                w_offset = IDX_W'(k);
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_offset};
        if (w_sum >= c_num_req) begin
            w_sum = w_sum - c_num_req;
        end
        o_index = w_sum[IDX_W-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            o_grant[i] = o_found && (o_index == IDX_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmd_credit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_credit_arbiter
//  Description : N-channel command arbiter with separate read and write
//                credit pools. Grants at most one channel per cycle, gated
//                by the credit pool of that channel's class, with fixed or
//                round-robin priority. Credits return on PSL responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_credit_arbiter
    import cmd_credit_arbiter_pkg::*;
#(
    parameter int NUM_CHANNELS  = CMD_ARB_NUM_CHANNELS,
    parameter int CREDITS_READ  = 32,
    parameter int CREDITS_WRITE = 32,
    parameter int CREDITS_TOTAL = CREDITS_READ + CREDITS_WRITE,
    parameter int CH_W          = $clog2(NUM_CHANNELS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enabled_in,
    input  logic                    priority_mode_in,
    input  logic [NUM_CHANNELS-1:0] req_in,
    input  logic [NUM_CHANNELS-1:0] req_is_write_in,
    output logic [NUM_CHANNELS-1:0] grant_out,
    output logic                    cmd_valid_out,
    output logic [CH_W-1:0]         cmd_channel_out,
    output logic                    cmd_is_write_out,
    input  logic                    rsp_credit_valid_in,
    input  logic                    rsp_credit_is_write_in,
    output logic [6:0]              credits_read_out,
    output logic [6:0]              credits_write_out,
    output logic                    credit_error_out
);

    if (CREDITS_TOTAL > 64) begin : g_check_credits
        $error("cmd_credit_arbiter: CREDITS_TOTAL must not exceed 64");
    end
    if (NUM_CHANNELS < 2 || NUM_CHANNELS > 16) begin : g_check_channels
        $error("cmd_credit_arbiter: NUM_CHANNELS must be in 2..16");
    end

    logic [NUM_CHANNELS-1:0] w_eligible;
    logic [NUM_CHANNELS-1:0] w_grant;
    logic                    w_found;
    logic [CH_W-1:0]         w_index;
    logic [CH_W-1:0]         w_ptr;
    logic                    w_grant_is_write;
    logic [1:0]              w_pool_take;
    logic [1:0]              w_pool_give;
    logic [1:0]              w_pool_avail;
    logic [1:0]              w_pool_overflow;

    logic [CH_W-1:0]         r_rr_ptr;
    logic                    r_cmd_valid;
    logic [CH_W-1:0]         r_cmd_channel;
    logic                    r_cmd_is_write;
    logic                    r_credit_error;

    // A channel competes only when enabled, requesting and its pool has credit
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_eligible[i] = !reset && enabled_in && req_in[i] &&
                            (req_is_write_in[i] ? w_pool_avail[POOL_WRITE]
                                                : w_pool_avail[POOL_READ]);
        end
    end

    // Fixed mode is the same search anchored at index 0
    assign w_ptr = (arb_mode_e'(priority_mode_in) == ROUND_ROBIN) ? r_rr_ptr : '0;

    cmd_credit_arbiter_rr_priority_select #(
        .NUM_REQ (NUM_CHANNELS),
        .IDX_W   (CH_W)
    ) u_select (
        .i_req   (w_eligible),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_found (w_found),
        .o_index (w_index)
    );

    assign grant_out        = w_grant;
    assign w_grant_is_write = |(w_grant & req_is_write_in);

    assign w_pool_take[POOL_WRITE] = w_found && w_grant_is_write;
    assign w_pool_take[POOL_READ]  = w_found && !w_grant_is_write;
    assign w_pool_give[POOL_WRITE] = rsp_credit_valid_in && rsp_credit_is_write_in;
    assign w_pool_give[POOL_READ]  = rsp_credit_valid_in && !rsp_credit_is_write_in;

    for (genvar p = 0; p < 2; p++) begin : g_pool
        localparam credit_count_t c_max =
            credit_count_t'((p == POOL_WRITE) ? CREDITS_WRITE : CREDITS_READ);

        credit_count_t r_count;
        logic          w_full;

        assign w_full             = (r_count == c_max);
        assign w_pool_avail[p]    = (r_count != '0);
        assign w_pool_overflow[p] = w_pool_give[p] && !w_pool_take[p] && w_full;

        // Take and give in one cycle cancel; a give to a full pool is dropped
        always_ff @(posedge clock) begin
            if (reset) begin
                r_count <= c_max;
            end else if (w_pool_take[p] && !w_pool_give[p]) begin
                r_count <= r_count - credit_count_t'(1);
            end else if (w_pool_give[p] && !w_pool_take[p] && !w_full) begin
                r_count <= r_count + credit_count_t'(1);
            end
        end
    end

    assign credits_read_out  = g_pool[POOL_READ].r_count;
    assign credits_write_out = g_pool[POOL_WRITE].r_count;

    // Pointer follows every grant in both modes so a mode switch stays fair
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_index == CH_W'(NUM_CHANNELS - 1)) ? '0
                                                             : w_index + CH_W'(1);
        end
    end

    // Registered command presented to the PSL one cycle after the transfer
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cmd_valid    <= 1'b0;
            r_cmd_channel  <= '0;
            r_cmd_is_write <= 1'b0;
        end else begin
            r_cmd_valid <= w_found;
            if (w_found) begin
                r_cmd_channel  <= w_index;
                r_cmd_is_write <= w_grant_is_write;
            end
        end
    end

    // Sticky flag for a credit returned to an already full pool
    always_ff @(posedge clock) begin
        if (reset) begin
            r_credit_error <= 1'b0;
        end else if (|w_pool_overflow) begin
            r_credit_error <= 1'b1;
        end
    end

    assign cmd_valid_out    = r_cmd_valid;
    assign cmd_channel_out  = r_cmd_channel;
    assign cmd_is_write_out = r_cmd_is_write;
    assign credit_error_out = r_credit_error;

endmodule
`default_nettype wire

// File: tb/tb_cmd_credit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmd_credit_arbiter
//  Description : Directed scoreboard bench for cmd_credit_arbiter. The driver
//                applies one vector per cycle and queues its expectations; a
//                monitor on the falling edge pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_credit_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       enabled_in;
    logic       priority_mode_in;
    logic [5:0] req_in;
    logic [5:0] req_is_write_in;
    logic [5:0] grant_out;
    logic       cmd_valid_out;
    logic [2:0] cmd_channel_out;
    logic       cmd_is_write_out;
    logic       rsp_credit_valid_in;
    logic       rsp_credit_is_write_in;
    logic [6:0] credits_read_out;
    logic [6:0] credits_write_out;
    logic       credit_error_out;

    cmd_credit_arbiter dut (
        .clock                  (clock),
        .reset                  (reset),
        .enabled_in             (enabled_in),
        .priority_mode_in       (priority_mode_in),
        .req_in                 (req_in),
        .req_is_write_in        (req_is_write_in),
        .grant_out              (grant_out),
        .cmd_valid_out          (cmd_valid_out),
        .cmd_channel_out        (cmd_channel_out),
        .cmd_is_write_out       (cmd_is_write_out),
        .rsp_credit_valid_in    (rsp_credit_valid_in),
        .rsp_credit_is_write_in (rsp_credit_is_write_in),
        .credits_read_out       (credits_read_out),
        .credits_write_out      (credits_write_out),
        .credit_error_out       (credit_error_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0] eg;
        int         ecr;
        int         ecw;
        logic       eerr;
        logic       evalid;
    } vec_t;

    typedef struct {
        int   ch;
        logic wr;
    } cmd_t;

    vec_t       vq[$];
    cmd_t       cq[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [5:0] last_eg  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus and queue what the DUT must show during it
    task automatic vec(input logic rst, input logic en, input logic mode,
                       input logic [5:0] req, input logic [5:0] wr,
                       input logic rv, input logic rw,
                       input logic [5:0] eg, input int ecr, input int ecw,
                       input logic eerr);
        vec_t v;
        cmd_t c;
        @(posedge clock);
        #1;
        reset                  = rst;
        enabled_in             = en;
        priority_mode_in       = mode;
        req_in                 = req;
        req_is_write_in        = wr;
        rsp_credit_valid_in    = rv | rw;
        rsp_credit_is_write_in = rw;
        v.eg     = eg;
        v.ecr    = ecr;
        v.ecw    = ecw;
        v.eerr   = eerr;
        v.evalid = (last_eg != 6'b0);
        vq.push_back(v);
        for (int i = 0; i < 6; i++) begin
            if (eg[i]) begin
                c.ch = i;
                c.wr = wr[i];
                cq.push_back(c);
            end
        end
        last_eg = rst ? 6'b0 : eg;
    endtask

    // Monitor: compare the current cycle's expectations away from the edge
    always @(negedge clock) begin
        vec_t v;
        cmd_t c;
        if (vq.size() > 0) begin
            v = vq.pop_front();
            check("grant_out",         32'(grant_out),         32'(v.eg));
            check("credits_read_out",  32'(credits_read_out),  v.ecr);
            check("credits_write_out", 32'(credits_write_out), v.ecw);
            check("credit_error_out",  32'(credit_error_out),  32'(v.eerr));
            check("cmd_valid_out",     32'(cmd_valid_out),     32'(v.evalid));
        end
        if (cmd_valid_out === 1'b1) begin
            if (cq.size() == 0) begin
                check("cmd_unexpected", 32'd1, 32'd0);
            end else begin
                c = cq.pop_front();
                check("cmd_channel_out",  32'(cmd_channel_out),  c.ch);
                check("cmd_is_write_out", 32'(cmd_is_write_out), 32'(c.wr));
            end
        end
    end

    initial begin
        int         rr_r [7] = '{32, 31, 31, 30, 30, 29, 29};
        int         rr_w [7] = '{32, 32, 31, 31, 30, 30, 29};
        logic [5:0] one_hot;

        reset                  = 1'b1;
        enabled_in             = 1'b0;
        priority_mode_in       = 1'b0;
        req_in                 = '0;
        req_is_write_in        = '0;
        rsp_credit_valid_in    = 1'b0;
        rsp_credit_is_write_in = 1'b0;
        repeat (2) @(posedge clock);

        // Reset state: requests pending but grant forced low
        vec(1, 1, 0, 6'b111111, 6'b0, 0, 0, 6'b0, 32, 32, 0);

        // Fixed priority drains the read pool through channel 0
        for (int i = 0; i < 32; i++) begin
            vec(0, 1, 0, 6'b000101, 6'b0, 0, 0, 6'b000001, 32 - i, 32, 0);
        end
        vec(0, 1, 0, 6'b000101, 6'b0, 0, 0, 6'b0, 0, 32, 0);
        vec(0, 1, 0, 6'b000101, 6'b0, 0, 0, 6'b0, 0, 32, 0);

        // Reload, then round-robin across all six channels with mixed classes
        vec(1, 0, 0, 6'b0, 6'b0, 0, 0, 6'b0, 0, 32, 0);
        for (int k = 0; k < 7; k++) begin
            one_hot = 6'b000001 << (k % 6);
            vec(0, 1, 1, 6'b111111, 6'b101010, 0, 0, one_hot, rr_r[k], rr_w[k], 0);
        end

        // Drain reads to zero
        for (int i = 0; i < 28; i++) begin
            vec(0, 1, 0, 6'b000001, 6'b0, 0, 0, 6'b000001, 28 - i, 29, 0);
        end

        // Read pool empty: the write channel wins, a read return unblocks ch0
        vec(0, 1, 0, 6'b000011, 6'b000010, 0, 0, 6'b000010, 0, 29, 0);
        vec(0, 1, 0, 6'b000011, 6'b000010, 1, 0, 6'b000010, 0, 28, 0);
        vec(0, 1, 0, 6'b000011, 6'b000010, 0, 0, 6'b000001, 1, 27, 0);
        vec(0, 1, 0, 6'b000011, 6'b000010, 0, 0, 6'b000010, 0, 27, 0);

        // Drain writes to 10, then grant and return on the write pool together
        for (int i = 0; i < 16; i++) begin
            vec(0, 1, 0, 6'b000010, 6'b000010, 0, 0, 6'b000010, 0, 26 - i, 0);
        end
        vec(0, 1, 0, 6'b000010, 6'b000010, 0, 1, 6'b000010, 0, 10, 0);
        vec(0, 1, 0, 6'b0, 6'b0, 0, 0, 6'b0, 0, 10, 0);

        // Reach 31/31, then read grant with a write return
        vec(1, 0, 0, 6'b0, 6'b0, 0, 0, 6'b0, 0, 10, 0);
        vec(0, 1, 0, 6'b000001, 6'b0, 0, 0, 6'b000001, 32, 32, 0);
        vec(0, 1, 0, 6'b000010, 6'b000010, 0, 0, 6'b000010, 31, 32, 0);
        vec(0, 1, 0, 6'b000001, 6'b0, 0, 1, 6'b000001, 31, 31, 0);
        vec(0, 1, 0, 6'b0, 6'b0, 0, 0, 6'b0, 30, 32, 0);

        // Return to a full write pool: count saturates, error is sticky
        vec(0, 1, 0, 6'b0, 6'b0, 0, 1, 6'b0, 30, 32, 0);
        vec(0, 1, 0, 6'b0, 6'b0, 1, 0, 6'b0, 30, 32, 1);
        vec(0, 1, 0, 6'b0, 6'b0, 0, 0, 6'b0, 31, 32, 1);

        // Burst down to 5 read credits, then reset mid-burst
        for (int i = 0; i < 26; i++) begin
            vec(0, 1, 0, 6'b000001, 6'b0, 0, 0, 6'b000001, 31 - i, 32, 1);
        end
        vec(1, 1, 0, 6'b000001, 6'b0, 0, 0, 6'b0, 5, 32, 1);
        // Pointer was 1 before reset; a grant to ch0 shows it cleared
        vec(0, 1, 1, 6'b111111, 6'b0, 0, 0, 6'b000001, 32, 32, 0);

        // Disabled: no grants, returns still counted
        vec(0, 0, 1, 6'b111111, 6'b0, 0, 0, 6'b0, 31, 32, 0);
        vec(0, 0, 1, 6'b111111, 6'b0, 1, 0, 6'b0, 31, 32, 0);
        vec(0, 0, 1, 6'b111111, 6'b0, 0, 0, 6'b0, 32, 32, 0);
        // Re-enabled: round-robin resumes from the pointer left at 1
        vec(0, 1, 1, 6'b111111, 6'b0, 0, 0, 6'b000010, 32, 32, 0);
        vec(0, 1, 1, 6'b0, 6'b0, 0, 0, 6'b0, 31, 32, 0);
        vec(0, 1, 1, 6'b0, 6'b0, 0, 0, 6'b0, 31, 32, 0);

        @(negedge clock);
        @(negedge clock);
        #1;
        check("vector_queue_drained",  32'(vq.size()), 32'd0);
        check("command_queue_drained", 32'(cq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_credit_arbiter.md
Name: cmd_credit_arbiter

Overview:
Parametrised N-channel command arbiter with separate read and write credit pools. It sits between the CU/AFU command buffers (restart, WED, write, read, prefetch-write, prefetch-read) and the PSL command interface. Each cycle it grants at most one channel, and only if the pool for that channel's class has a free credit. Priority is either fixed or round-robin, selectable at runtime. Credits return on PSL responses.

Parameters:
NUM_CHANNELS, 6, number of requesting command buffers; range 2..16
CREDITS_READ, 32, initial and maximum read credits
CREDITS_WRITE, 32, initial and maximum write credits
CREDITS_TOTAL, CREDITS_READ+CREDITS_WRITE, elaboration check: must be ≤64, otherwise $error
CH_W, $clog2(NUM_CHANNELS), width of the channel index

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
enabled_in  in  1  when 0, no grants are issued; credits still return
priority_mode_in  in  1  0 = fixed (index 0 highest), 1 = round-robin
req_in  in  NUM_CHANNELS  per-channel command pending (valid)
req_is_write_in  in  NUM_CHANNELS  per-channel class: 1 = write pool, 0 = read pool
grant_out  out  NUM_CHANNELS  one-hot or zero, combinational (ready)
cmd_valid_out  out  1  registered: a grant occurred in the previous cycle
cmd_channel_out  out  CH_W  registered index of the granted channel
cmd_is_write_out  out  1  registered class of the granted command
rsp_credit_valid_in  in  1  one credit returned this cycle
rsp_credit_is_write_in  in  1  pool of the returned credit
credits_read_out  out  7  current read credit count
credits_write_out  out  7  current write credit count
credit_error_out  out  1  sticky: credit returned to a pool already at maximum

Behaviour:
- Transfer occurs when req_in[i] & grant_out[i] in the same cycle. The requester advances its buffer on that cycle.
- Eligibility: eligible[i] = enabled_in & req_in[i] & (req_is_write_in[i] ? credits_write>0 : credits_read>0).
- grant_out is a pure function of eligible, priority_mode_in and rr_ptr (registered). It never depends on the credit return in the same cycle.
- Fixed mode: grant the lowest eligible index.
- Round-robin mode: search upward from rr_ptr with wrap; grant the first eligible index.
- rr_ptr: on any grant, rr_ptr <= (granted index + 1) mod NUM_CHANNELS. It holds when there is no grant. It also updates in fixed mode, so a mode switch stays coherent. A mode change applies in the same cycle.
- Credit counters are per pool and update next clock:
  - grant only: −1
  - return only: +1
  - grant and return on the same pool in the same cycle: unchanged
  - grant and return on different pools: each pool updates independently
- Return to a full pool: the count stays at maximum and credit_error_out sets to 1. It clears only on reset.
- Counters never go below 0, guaranteed by the eligibility gate.
- Output register: cmd_valid_out <= |grant_out. On a grant, cmd_channel_out and cmd_is_write_out capture the granted index and class. With no grant they hold their old values. Latency from transfer to cmd_valid_out is 1 cycle.
- Reset values:
  - grant_out = 0 (forced while reset is high)
  - cmd_valid_out = 0, cmd_channel_out = 0, cmd_is_write_out = 0
  - credits_read = CREDITS_READ, credits_write = CREDITS_WRITE
  - rr_ptr = 0, credit_error_out = 0
- Reset mid-operation: in-flight credits are discarded and counters reload to full. Upstream logic is required to be reset simultaneously.
- enabled_in = 0: grant_out = 0; credit returns are still accepted.

Decomposition:
- The shared globals package gains:
  - CMD_ARB_NUM_CHANNELS
  - an enum for arbitration mode (FIXED = 0, ROUND_ROBIN = 1)
  - a credit_count_t typedef (7 bits)
  - the PRIORITY_* channel indices, used as channel numbers on req_in
- One sub-module is natural: rr_priority_select. It is a combinational N-way "first set bit at or after pointer, with wrap" search; fixed mode calls it with pointer = 0.
- The credit counters stay inline, one instance per pool, generated from a common always_ff pattern.

Test Plan:
1. Reset, then req_in=6'b000101, all reads, fixed mode → grant_out=000001 each cycle; credits_read falls 32→0 over 32 cycles; then grant_out=0 with credits_read_out=0.
2. Round-robin, req_in=6'b111111, mixed classes, ample credits → grants cycle 0,1,2,3,4,5,0. cmd_channel_out follows one cycle later with cmd_valid_out=1.
3. credits_read=0, ch0 is a read, ch1 is a write, both requesting → ch1 granted; ch0 blocked. One read return → next cycle ch0 is eligible and granted in fixed mode.
4. Grant on the write pool plus a write return in the same cycle at credits_write=10 → stays 10. Grant on read plus return on write at 31/31 → read 30, write 32.
5. Return to the write pool at credits_write=32 → stays 32 and credit_error_out=1, which persists until reset.
6. Assert reset for 1 cycle mid-burst with credits_read=5 → next cycle credits_read=32, cmd_valid_out=0, rr_ptr=0. enabled_in=0 with requests pending → grant_out=0 while returns still increment the counters.
